sw_step_conditioner: RTL and testbench
======================================

// Module: sw_step_conditioner
// PURPOSE
//   Input conditioner for the 20-state up/down display counter. Sits directly upstream of that counter.
//   Synchronises and debounces the raw step button (SW1) and direction switch (SW2).
//   Emits a one-clock step_pulse per press, with optional auto-repeat while the button is held.
//   Emits a debounced dir level. The counter consumes step_pulse as its count enable and dir as up(0)/down(1).
// PARAMETERS
//   DEBOUNCE_CYCLES  500000    consecutive clocks a synchronised input must differ from its stable value before it is accepted (>=1)
//   REPEAT_EN        1         1: auto-repeat while held; 0: exactly one pulse per press
//   HOLD_CYCLES      25000000  clocks from first pulse to first repeat pulse (>=1)
//   REPEAT_CYCLES    10000000  clocks between subsequent repeat pulses (>=1)
// PORTS
//   clock       in   1  system clock, 50 MHz
//   reset_n     in   1  asynchronous, active-low reset
//   btn_raw     in   1  raw step button, asynchronous, may bounce
//   dir_raw     in   1  raw direction switch, asynchronous, may bounce
//   step_pulse  out  1  one-clock-wide step request to the counter
//   dir         out  1  debounced direction, 0 = up, 1 = down
//   btn_level   out  1  debounced button level, for status LED
// BEHAVIOUR
//   Reset
//     - reset_n low asynchronously clears all flops: synchronisers, debounce counters, timers.
//     - FSM goes to IDLE; step_pulse=0, dir=0, btn_level=0.
//   Synchroniser
//     - Each raw input passes through a 2-flop synchroniser.
//   Debounce (one instance per input)
//     - Counter increments each clock while sync != stable value.
//     - Counter clears on any clock where sync == stable value.
//     - When the counter reaches DEBOUNCE_CYCLES, the stable value toggles and the counter clears.
//     - Latency: a raw edge before clock edge k yields a stable change at edge k+1+DEBOUNCE_CYCLES.
//     - Counter width is $clog2(DEBOUNCE_CYCLES+1). The counter never wraps.
//   FSM states: IDLE, HOLD, REPEAT. A single timer, width $clog2(max(HOLD,REPEAT)+1), serves both.
//     - IDLE: btn stable 0->1 => step_pulse=1 for this cycle, timer=0, go to HOLD.
//     - HOLD: btn stable 0 => go to IDLE, no pulse.
//       Else, if REPEAT_EN and timer==HOLD_CYCLES-1 => pulse, timer=0, go to REPEAT. Else timer++.
//       With REPEAT_EN=0 the timer is frozen and the FSM waits for release.
//     - REPEAT: btn stable 0 => go to IDLE, no pulse.
//       Else, if timer==REPEAT_CYCLES-1 => pulse, timer=0. Else timer++.
//     - Release and timer expiry in the same cycle: release wins, no pulse.
//     - step_pulse is registered and never high on two consecutive clocks, given that HOLD_CYCLES>=2 and REPEAT_CYCLES>=2.
//   Direction coherence
//     - dir must not change in a cycle where step_pulse is high.
//     - If the dir debounce completes in that cycle, its counter saturates and dir updates one clock later.
//     - The counter samples dir together with step_pulse and always sees the pre-change value.
//   Power-up
//     - If btn_raw is already high at reset release, this is treated as a fresh press.
//     - First pulse appears DEBOUNCE_CYCLES+2 clocks after reset release.
// TESTING  (bench overrides DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=5; clock period 20 ns; cycle n = n-th rising edge after the stimulus)
//   1. reset_n=0 with btn_raw=1, dir_raw=1 -> step_pulse=0, dir=0, btn_level=0 throughout. Release reset -> one pulse in cycle 6.
//   2. btn_raw 0->1 held 12 clks, REPEAT_EN=0 -> exactly one pulse in cycle 6; btn_level=1 from cycle 6 until 6 clks after release.
//   3. btn_raw toggling every clock for 10 clks, then steady 1 -> exactly one pulse. A 3-clock high glitch alone -> no pulse.
//   4. btn_raw held 38 clks, REPEAT_EN=1 -> 7 pulses at cycles 6,16,21,26,31,36,41; none after btn_level falls.
//   5. dir_raw flipped so its debounce completes on the same cycle as a pulse -> dir holds the old value on the pulse cycle and flips the next cycle.
//   6. reset_n pulsed low mid-REPEAT with btn_raw held 1 -> outputs 0 immediately. After release: one pulse 6 clks later, then a repeat pulse 10 clks after that.

Source files
------------

// File: rtl/sw_step_conditioner.sv
`timescale 1ns/1ps
// Button/direction input conditioner: 2-flop synchronisers, debouncers, and a
// press/hold/auto-repeat FSM producing one-clock step pulses for the display counter.
module sw_step_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter bit          REPEAT_EN       = 1'b1,
  parameter int unsigned HOLD_CYCLES     = 25000000,
  parameter int unsigned REPEAT_CYCLES   = 10000000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic btn_raw,
  input  logic dir_raw,
  output logic step_pulse,
  output logic dir,
  output logic btn_level
);

  localparam int unsigned CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned TMR_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DB_FULL   = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(HOLD_CYCLES - 1);
  localparam logic [TMR_W-1:0] REP_LAST  = TMR_W'(REPEAT_CYCLES - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_HOLD   = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;

  logic             btn_s1_q, btn_s2_q, dir_s1_q, dir_s2_q;
  logic [CNT_W-1:0] btn_cnt_q, btn_cnt_d, dir_cnt_q, dir_cnt_d;
  logic             btn_stable_q, btn_stable_d, dir_q, dir_d;
  logic [1:0]       state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             step_pulse_q, step_pulse_d;

  // Button debounce; the stable value flips on the clock the run length completes.
  always_comb begin
    btn_cnt_d    = btn_cnt_q;
    btn_stable_d = btn_stable_q;
    if (btn_s2_q == btn_stable_q) begin
      btn_cnt_d = '0;
    end else if (btn_cnt_q >= DB_LAST) begin
      btn_stable_d = ~btn_stable_q;
      btn_cnt_d    = '0;
    end else begin
      btn_cnt_d = btn_cnt_q + CNT_W'(1);
    end
  end

  // Press/hold/repeat FSM; acts on the next stable level so release beats expiry.
  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    step_pulse_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (btn_stable_d && !btn_stable_q) begin
          step_pulse_d = 1'b1;
          timer_d      = '0;
          state_d      = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (!btn_stable_d) begin
          timer_d = '0;
          state_d = ST_IDLE;
        end else if (REPEAT_EN) begin
          if (timer_q == HOLD_LAST) begin
            step_pulse_d = 1'b1;
            timer_d      = '0;
            state_d      = ST_REPEAT;
          end else begin
            timer_d = timer_q + TMR_W'(1);
          end
        end
      end
      ST_REPEAT: begin
        if (!btn_stable_d) begin
          timer_d = '0;
          state_d = ST_IDLE;
        end else if (timer_q == REP_LAST) begin
          step_pulse_d = 1'b1;
          timer_d      = '0;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      default: begin
        timer_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Direction debounce; a completion colliding with a pulse saturates and lands a clock later.
  always_comb begin
    dir_cnt_d = dir_cnt_q;
    dir_d     = dir_q;
    if (dir_s2_q == dir_q) begin
      dir_cnt_d = '0;
    end else if (dir_cnt_q >= DB_LAST) begin
      if (step_pulse_d) begin
        dir_cnt_d = DB_FULL;
      end else begin
        dir_d     = ~dir_q;
        dir_cnt_d = '0;
      end
    end else begin
      dir_cnt_d = dir_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      btn_s1_q     <= 1'b0;
      btn_s2_q     <= 1'b0;
      dir_s1_q     <= 1'b0;
      dir_s2_q     <= 1'b0;
      btn_cnt_q    <= '0;
      btn_stable_q <= 1'b0;
      dir_cnt_q    <= '0;
      dir_q        <= 1'b0;
      state_q      <= ST_IDLE;
      timer_q      <= '0;
      step_pulse_q <= 1'b0;
    end else begin
      btn_s1_q     <= btn_raw;
      btn_s2_q     <= btn_s1_q;
      dir_s1_q     <= dir_raw;
      dir_s2_q     <= dir_s1_q;
      btn_cnt_q    <= btn_cnt_d;
      btn_stable_q <= btn_stable_d;
      dir_cnt_q    <= dir_cnt_d;
      dir_q        <= dir_d;
      state_q      <= state_d;
      timer_q      <= timer_d;
      step_pulse_q <= step_pulse_d;
    end
  end

  assign step_pulse = step_pulse_q;
  assign dir        = dir_q;
  assign btn_level  = btn_stable_q;

endmodule

// File: tb/tb_sw_step_conditioner.sv
`timescale 1ns/1ps
// Self-checking bench for sw_step_conditioner: hand tables, corner sequences,
// and randomized stimulus against a run-length behavioural model.
module tb_sw_step_conditioner;

  localparam int unsigned DB  = 4;
  localparam int unsigned HLD = 10;
  localparam int unsigned REP = 5;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic btn_raw = 1'b1;
  logic dir_raw = 1'b1;
  logic sp_r, dir_r, lvl_r, sp_n, dir_n, lvl_n;

  int checks = 0;
  int failures = 0;

  sw_step_conditioner #(.DEBOUNCE_CYCLES(DB), .REPEAT_EN(1'b1), .HOLD_CYCLES(HLD),
                        .REPEAT_CYCLES(REP)) dut_rep (
    .clock(clock), .reset_n(reset_n), .btn_raw(btn_raw), .dir_raw(dir_raw),
    .step_pulse(sp_r), .dir(dir_r), .btn_level(lvl_r));

  sw_step_conditioner #(.DEBOUNCE_CYCLES(DB), .REPEAT_EN(1'b0), .HOLD_CYCLES(HLD),
                        .REPEAT_CYCLES(REP)) dut_nr (
    .clock(clock), .reset_n(reset_n), .btn_raw(btn_raw), .dir_raw(dir_raw),
    .step_pulse(sp_n), .dir(dir_n), .btn_level(lvl_n));

  always #10 clock = ~clock;

  // Behavioural model state: raw delay line, run lengths, press timing.
  logic mb1, mb2, md1, md2;
  logic m_level, m_dir, m_held, m_pulse_rep, m_pulse_nr;
  int   m_brun, m_drun, m_since, m_nrep;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s at t=%0t: got=%0d exp=%0d", name, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    mb1 = 0; mb2 = 0; md1 = 0; md2 = 0;
    m_level = 0; m_dir = 0; m_held = 0; m_pulse_rep = 0; m_pulse_nr = 0;
    m_brun = 0; m_drun = 0; m_since = 0; m_nrep = 0;
  endtask

  task automatic model_step(input logic b, input logic d);
    logic bs, ds, prev, rise, fall;
    bs = mb2; ds = md2;
    mb2 = mb1; mb1 = b; md2 = md1; md1 = d;
    prev = m_level;
    if (bs == m_level) m_brun = 0;
    else begin
      m_brun++;
      if (m_brun == int'(DB)) begin m_level = ~m_level; m_brun = 0; end
    end
    rise = m_level & ~prev;
    fall = prev & ~m_level;
    m_pulse_nr = rise;
    m_pulse_rep = 0;
    if (rise) begin
      m_held = 1; m_since = 0; m_nrep = 0; m_pulse_rep = 1;
    end else if (fall) begin
      m_held = 0;
    end else if (m_held) begin
      m_since++;
      if (m_since == ((m_nrep == 0) ? int'(HLD) : int'(REP))) begin
        m_pulse_rep = 1; m_since = 0; m_nrep++;
      end
    end
    if (ds == m_dir) m_drun = 0;
    else begin
      m_drun++;
      if (m_drun >= int'(DB)) begin
        if (m_pulse_rep) m_drun = int'(DB);
        else begin m_dir = ~m_dir; m_drun = 0; end
      end
    end
  endtask

  // One clock: drive on the falling edge, model the rising edge, sample 1 ns later.
  task automatic tick(input logic b, input logic d);
    @(negedge clock);
    btn_raw = b; dir_raw = d;
    @(posedge clock);
    model_step(b, d);
    #1;
    check("model_pulse_rep", int'(sp_r), int'(m_pulse_rep));
    check("model_pulse_nr", int'(sp_n), int'(m_pulse_nr));
    check("model_level_rep", int'(lvl_r), int'(m_level));
    check("model_level_nr", int'(lvl_n), int'(m_level));
    check("model_dir_rep", int'(dir_r), int'(m_dir));
  endtask

  typedef struct packed {
    logic btn;
    logic dir_in;
    logic p_rep;
    logic p_nr;
    logic lvl;
    logic dr;
  } vec_t;

  vec_t vecs[$];
  int   pulses[$];
  int   cnt_r, cnt_n, lvl_seen;
  int   exp4[7] = '{6, 16, 21, 26, 31, 36, 41};

  initial begin
    vec_t v;
    // Power-up press with dir=1 (dir completes with the pulse, so lands at cycle 7).
    for (int c = 1; c <= 16; c++) begin
      v.btn = (c <= 8); v.dir_in = 1'b1;
      v.p_rep = (c == 6); v.p_nr = (c == 6);
      v.lvl = (c >= 6 && c < 14); v.dr = (c >= 7);
      vecs.push_back(v);
    end
    // 12-clock press: single pulse without repeat, repeat at 16 with it.
    for (int c = 1; c <= 20; c++) begin
      v.btn = (c <= 12); v.dir_in = 1'b1;
      v.p_rep = (c == 6 || c == 16); v.p_nr = (c == 6);
      v.lvl = (c >= 6 && c < 18); v.dr = 1'b1;
      vecs.push_back(v);
    end

    model_reset();
    // Reset held with both raw inputs high.
    repeat (4) begin
      @(negedge clock);
      check("reset_pulse", int'(sp_r | sp_n), 0);
      check("reset_dir", int'(dir_r | dir_n), 0);
      check("reset_level", int'(lvl_r | lvl_n), 0);
    end
    @(posedge clock); #2;
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      tick(vecs[i].btn, vecs[i].dir_in);
      check($sformatf("vec%0d_pulse_rep", i), int'(sp_r), int'(vecs[i].p_rep));
      check($sformatf("vec%0d_pulse_nr", i), int'(sp_n), int'(vecs[i].p_nr));
      check($sformatf("vec%0d_level", i), int'(lvl_r), int'(vecs[i].lvl));
      check($sformatf("vec%0d_dir", i), int'(dir_r), int'(vecs[i].dr));
    end

    // Bouncing press then steady: one pulse. Short glitch: nothing.
    cnt_r = 0; cnt_n = 0;
    for (int i = 0; i < 25; i++) begin
      tick((i < 10) ? logic'(i % 2 == 0) : 1'b1, 1'b1);
      cnt_r += int'(sp_r); cnt_n += int'(sp_n);
    end
    check("bounce_pulses_nr", cnt_n, 1);
    check("bounce_pulses_rep", cnt_r, 1);
    repeat (12) tick(1'b0, 1'b1);
    cnt_r = 0; cnt_n = 0; lvl_seen = 0;
    for (int i = 0; i < 15; i++) begin
      tick(i < 3, 1'b1);
      cnt_r += int'(sp_r); cnt_n += int'(sp_n); lvl_seen |= int'(lvl_r);
    end
    check("glitch_pulses", cnt_r + cnt_n, 0);
    check("glitch_level", lvl_seen, 0);

    // Long hold with auto-repeat.
    pulses.delete();
    for (int c = 1; c <= 50; c++) begin
      tick(c <= 38, 1'b1);
      if (sp_r) pulses.push_back(c);
      if (c == 43) check("hold_level_c43", int'(lvl_r), 1);
      if (c == 44) check("hold_level_c44", int'(lvl_r), 0);
    end
    check("hold_pulse_count", pulses.size(), 7);
    for (int i = 0; i < 7; i++)
      check($sformatf("hold_pulse%0d_cycle", i), (i < pulses.size()) ? pulses[i] : -1, exp4[i]);

    // Direction debounce completing on the pulse cycle.
    for (int c = 1; c <= 20; c++) begin
      tick(c <= 10, 1'b0);
      if (c == 6) begin
        check("coh_pulse", int'(sp_r & sp_n), 1);
        check("coh_dir_rep_c6", int'(dir_r), 1);
        check("coh_dir_nr_c6", int'(dir_n), 1);
      end
      if (c == 7) begin
        check("coh_dir_rep_c7", int'(dir_r), 0);
        check("coh_dir_nr_c7", int'(dir_n), 0);
      end
    end

    // Asynchronous reset in the middle of REPEAT, button kept held.
    for (int c = 1; c <= 23; c++) tick(1'b1, 1'b1);
    check("pre_reset_level", int'(lvl_r), 1);
    check("pre_reset_dir", int'(dir_r), 1);
    #4 reset_n = 1'b0;
    #1;
    check("midreset_pulse", int'(sp_r | sp_n), 0);
    check("midreset_dir", int'(dir_r | dir_n), 0);
    check("midreset_level", int'(lvl_r | lvl_n), 0);
    repeat (3) @(posedge clock);
    #2;
    reset_n = 1'b1;
    model_reset();
    pulses.delete();
    for (int c = 1; c <= 20; c++) begin
      tick(1'b1, 1'b1);
      if (sp_r) pulses.push_back(c);
    end
    check("postreset_pulse_count", pulses.size(), 2);
    check("postreset_first", (pulses.size() > 0) ? pulses[0] : -1, 6);
    check("postreset_repeat", (pulses.size() > 1) ? pulses[1] : -1, 16);
    repeat (10) tick(1'b0, 1'b1);

    // Randomized segments checked against the model every clock.
    for (int s = 0; s < 60; s++) begin
      logic rb, rd;
      int len;
      rb = logic'($urandom_range(0, 1));
      rd = logic'($urandom_range(0, 1));
      len = int'($urandom_range(1, 24));
      for (int k = 0; k < len; k++) tick(rb, rd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
